// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter slice.
package rf_write_arbiter_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int REQ_MDU = 2;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// One-hot grant arbiter. RF_ARB_RR_EN selects round-robin with a rotating pointer;
// without it the block is a lowest-index-wins priority encoder.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

`ifdef RF_ARB_RR_EN
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;

    // Search starts at the pointer and wraps; offsets are scanned in order so the
    // first valid requester at or after the pointer wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        if (!reset) begin
            for (int k = 0; k < NREQ; k++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && req[i] && (i == ((int'(ptr_q) + k) % NREQ))) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (advance && grant[i]) begin
                ptr_d = PW'((i + 1) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic found;
    logic unused_rr;

    assign unused_rr = &{1'b0, clk, advance};

    always_comb begin
        grant = '0;
        found = 1'b0;
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i]) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter with registered write stage and pending-write scoreboard.
// Arbitration policy is round-robin when RF_ARB_RR_EN is defined, fixed priority otherwise.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_reg,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_reg,
    output logic [NUM_REGS-1:0]  busy,
    output logic [AW-1:0]        writeReg,
    output logic [DW-1:0]        writeData,
    output logic                 regWrite
);

    logic [NREQ-1:0]     grant;
    logic                transfer;
    logic [AW-1:0]       sel_reg;
    logic [DW-1:0]       sel_data;

    logic                reg_write_q, reg_write_d;
    logic [AW-1:0]       write_reg_q, write_reg_d;
    logic [DW-1:0]       write_data_q, write_data_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (transfer),
        .grant   (grant)
    );

    assign transfer  = |grant;
    assign req_ready = grant;

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_reg  = req_reg[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Writes to $zero are accepted so the requester can retire, but never reach the RF.
    always_comb begin
        reg_write_d  = transfer && (sel_reg != '0);
        write_reg_d  = transfer ? sel_reg  : write_reg_q;
        write_data_d = transfer ? sel_data : write_data_q;
    end

    // Set is applied after clear so a fresh reservation survives the older write retiring.
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q) begin
            busy_d[write_reg_q] = 1'b0;
        end
        if (rsv_valid && (rsv_reg != '0)) begin
            busy_d[rsv_reg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            busy_q       <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
        end
    end

    assign regWrite  = reg_write_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed scenarios then randomized traffic.
module tb_rf_write_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_reg;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rsv_valid;
    logic [AW-1:0]        rsv_reg;
    logic [31:0]          busy;
    logic [AW-1:0]        writeReg;
    logic [DW-1:0]        writeData;
    logic                 regWrite;

    always #5 clk = ~clk;

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_reg   (rsv_reg),
        .busy      (busy),
        .writeReg  (writeReg),
        .writeData (writeData),
        .regWrite  (regWrite)
    );

    typedef struct {
        int            cyc;
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_w;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    // Reference model state: committed values and values for the next edge.
    int              m_ptr = 0, ptr_nx = 0;
    logic [31:0]     m_busy = '0, busy_nx = '0;
    bit              cur_we = 1'b0, we_nx = 1'b0;
    logic [AW-1:0]   cur_reg = '0, reg_nx = '0;
    logic [NREQ-1:0] m_grant = '0;

    function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int ptr);
        int start;
`ifdef RF_ARB_RR_EN
        start = ptr;
`else
        start = 0 * ptr;
`endif
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (start + k) % NREQ;
            if (v[i]) return NREQ'(1) << i;
        end
        return '0;
    endfunction

    task automatic step(input bit rst, input logic [NREQ-1:0] v,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                        input bit rv, input logic [AW-1:0] rr);
        wr_t w;
        @(posedge clk);
        m_busy  = busy_nx;
        m_ptr   = ptr_nx;
        cur_we  = we_nx;
        cur_reg = reg_nx;
        cyc     = cyc + 1;
        mon_en  = 1'b1;
        #1;
        reset     = rst;
        req_valid = v;
        req_reg   = {r2, r1, r0};
        req_data  = {d2, d1, d0};
        rsv_valid = rv;
        rsv_reg   = rr;
        @(negedge clk);
        m_grant = rst ? '0 : model_grant(v, m_ptr);
        n_cmp++;
        if (req_ready !== m_grant) begin
            n_err++;
            $display("FAIL req_ready cyc %0d: got %b expected %b", cyc, req_ready, m_grant);
        end
        busy_nx = m_busy;
        ptr_nx  = m_ptr;
        we_nx   = 1'b0;
        reg_nx  = cur_reg;
        if (cur_we) busy_nx[cur_reg] = 1'b0;
        if (rv && rr != '0) busy_nx[rr] = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (m_grant[i]) begin
                ptr_nx = (i + 1) % NREQ;
                w.cyc = cyc + 1;
                w.r   = req_reg[i*AW +: AW];
                w.d   = req_data[i*DW +: DW];
                if (w.r != '0) begin
                    exp_q.push_back(w);
                    we_nx  = 1'b1;
                    reg_nx = w.r;
                end
            end
        end
        if (rst) begin
            busy_nx = '0;
            ptr_nx  = 0;
            we_nx   = 1'b0;
        end
    endtask

    task automatic idle(input bit rst);
        step(rst, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    endtask

    // Monitor: compares the write port and scoreboard against the model at each negedge.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (busy !== m_busy) begin
                n_err++;
                $display("FAIL busy cyc %0d: got %h expected %h", cyc, busy, m_busy);
            end
            if (regWrite === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    n_err++;
                    $display("FAIL unexpected_write cyc %0d: got reg %0d data %h, expected no write",
                             cyc, writeReg, writeData);
                end else begin
                    mon_w = exp_q.pop_front();
                    if (writeReg !== mon_w.r || writeData !== mon_w.d) begin
                        n_err++;
                        $display("FAIL write_port cyc %0d: got reg %0d data %h expected reg %0d data %h",
                                 cyc, writeReg, writeData, mon_w.r, mon_w.d);
                    end
                end
            end else if (regWrite !== 1'b0) begin
                n_cmp++;
                n_err++;
                $display("FAIL regWrite cyc %0d: got %b expected 0 or 1", cyc, regWrite);
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                mon_w = exp_q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missing_write cyc %0d: got regWrite 0 expected reg %0d data %h",
                         cyc, mon_w.r, mon_w.d);
            end
        end
    end

    logic [NREQ-1:0] hv;
    logic [AW-1:0]   hr[NREQ];
    logic [DW-1:0]   hd[NREQ];

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_reg   = '0;
        req_data  = '0;
        rsv_valid = 1'b0;
        rsv_reg   = '0;

        idle(1'b1);
        idle(1'b1);

        // single request, one-cycle latency
        step(1'b0, 3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 5'd0);
        idle(1'b0);
        idle(1'b0);

        // all requesters valid continuously
        for (int n = 0; n < 6; n++)
            step(1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'hA0 + n, 32'hB0 + n, 32'hC0 + n, 1'b0, 5'd0);
        idle(1'b0);

        // $zero write and $zero reservation
        step(1'b0, 3'b001, 5'd0, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0, 1'b0, 5'd0);
        idle(1'b0);
        step(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0);
        idle(1'b0);

        // reservation then completion of register 7
        step(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7);
        idle(1'b0);
        step(1'b0, 3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'h77, 32'h0, 1'b0, 5'd0);
        idle(1'b0);
        idle(1'b0);

        // completion of 9 coincides with a new reservation of 9
        step(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9);
        step(1'b0, 3'b001, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0, 1'b0, 5'd0);
        step(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9);
        idle(1'b0);
        idle(1'b0);

        // reset in the cycle after a transfer, then requester 2 alone
        step(1'b0, 3'b001, 5'd4, 5'd0, 5'd0, 32'h44, 32'h0, 32'h0, 1'b1, 5'd12);
        idle(1'b1);
        step(1'b0, 3'b100, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h66, 1'b0, 5'd0);
        idle(1'b0);

        // randomized traffic; a requester holds its request until granted
        hv = '0;
        for (int i = 0; i < NREQ; i++) begin
            hr[i] = '0;
            hd[i] = '0;
        end
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(hv[i] && !m_grant[i])) begin
                    hv[i] = ($urandom_range(0, 99) < 60);
                    hr[i] = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(1, 31));
                    hd[i] = $urandom;
                end
            end
            step($urandom_range(0, 99) == 0, hv, hr[0], hr[1], hr[2], hd[0], hd[1], hd[2],
                 $urandom_range(0, 99) < 30, AW'($urandom_range(0, 31)));
        end

        idle(1'b0);
        idle(1'b0);
        idle(1'b0);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d writes outstanding expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
